// File: rtl/bus_read_sequencer_pkg.sv
// Shared definitions for the bus read sequencer: FSM encodings, default
// settle interval and width helpers used by the interface and the RTL.
package bus_read_sequencer_pkg;

  // FSM state encodings (kept as plain vectors for legacy tool flows)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENABLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  // Default number of cycles an output enable is held before sampling
  localparam int DEFAULT_SETTLE = 2;

  // Width of a driver index; never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the settle down-counter, which holds values 0..s-1
  function automatic int cnt_width(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/bus_read_sequencer_if.sv
// Request/bus/response bundle between a requester, the shared tri-state bus
// and the read sequencer. The master modport is the sequencer side.
interface bus_read_sequencer_if #(
  parameter int WIDTH = 1,
  parameter int NSRC  = 4
);
  import bus_read_sequencer_pkg::*;

  localparam int SELW = sel_width(NSRC);

  logic             req;
  logic [SELW-1:0]  src_sel;
  logic [NSRC-1:0]  oe;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rready;
  logic             err;
  logic             busy;

  modport master (
    input  req, src_sel, bus_in, rready,
    output oe, rdata, rvalid, err, busy
  );

  modport slave (
    output req, src_sel, bus_in, rready,
    input  oe, rdata, rvalid, err, busy
  );

endinterface

// File: rtl/bus_read_sequencer_oe_decoder.sv
// Registered driver-index to one-hot output-enable decoder. An out-of-range
// index decodes to all-zero and raises o_range_err so no driver is enabled.
module bus_read_sequencer_oe_decoder #(
  parameter int NSRC = 4,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [SELW-1:0] i_sel,
  output logic [NSRC-1:0] o_oe,
  output logic            o_range_err
);

  localparam logic [SELW:0] SEL_LIMIT = (SELW + 1)'(NSRC);

  logic [NSRC-1:0] w_onehot;
  logic [NSRC-1:0] r_oe;

  assign o_range_err = ({1'b0, i_sel} >= SEL_LIMIT);

  // One-hot image of the index; an index past the last driver matches no bit
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_onehot[i] = (i_sel == SELW'(i));
    end
  end

  // Enable register: clear has priority over load so release is never delayed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oe <= '0;
    end else if (i_clr) begin
      r_oe <= '0;
    end else if (i_en) begin
      r_oe <= w_onehot;
    end else begin
      r_oe <= r_oe;
    end
  end

  assign o_oe = r_oe;

endmodule

// File: rtl/bus_read_sequencer.sv
// Read sequencer for a shared tri-state bus. Per request it enables one
// driver for SETTLE cycles, samples the bus as the enable drops, and offers
// the captured word on a valid/ready handshake. Only one enable is ever
// active, and the HOLD and IDLE cycles give a two-cycle released gap.
module bus_read_sequencer
  import bus_read_sequencer_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int NSRC   = 4,
  parameter int SETTLE = DEFAULT_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_read_sequencer_if.master bus
);

  localparam int SELW = sel_width(NSRC);
  localparam int CNTW = cnt_width(SETTLE);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [1:0]       r_state;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;
  logic             r_err;
  logic             r_busy;

  logic [NSRC-1:0]  w_oe;
  logic             w_range_err;
  logic             w_dec_en;
  logic             w_dec_clr;
  logic             w_bus_x;

  // Unknown or floating bus bits make the reduction unknown; synthesis sees 0
  assign w_bus_x = ((^bus.bus_in) === 1'bx);

  // Decoder control: load only on an IDLE request, release as ENABLE ends
  always_comb begin
    w_dec_en  = 1'b0;
    w_dec_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dec_en  = bus.req;
        w_dec_clr = 1'b0;
      end
      ST_ENABLE: begin
        w_dec_en  = 1'b0;
        w_dec_clr = (r_cnt == '0);
      end
      ST_HOLD: begin
        w_dec_en  = 1'b0;
        w_dec_clr = 1'b1;
      end
      default: begin
        w_dec_en  = 1'b0;
        w_dec_clr = 1'b1;
      end
    endcase
  end

  bus_read_sequencer_oe_decoder #(
    .NSRC (NSRC),
    .SELW (SELW)
  ) u_oe_decoder (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_dec_clr),
    .i_en        (w_dec_en),
    .i_sel       (bus.src_sel),
    .o_oe        (w_oe),
    .o_range_err (w_range_err)
  );

  // Read FSM with settle counter and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            r_busy <= 1'b1;
            if (w_range_err) begin
              // No driver exists for this index: answer at once with err
              r_rdata  <= '0;
              r_err    <= 1'b1;
              r_rvalid <= 1'b1;
              r_state  <= ST_HOLD;
            end else begin
              r_cnt   <= CNT_LOAD;
              r_state <= ST_ENABLE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ENABLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            // Sample on the same edge that releases the enable
            r_rdata  <= bus.bus_in;
            r_err    <= w_bus_x;
            r_rvalid <= 1'b1;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.rready) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_cnt    <= '0;
          r_rvalid <= 1'b0;
          r_err    <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oe     = w_oe;
  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.err    = r_err;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Self-checking bench: a transaction-level model predicts oe/rvalid/rdata/
// err/busy every cycle for a 4-source sequencer; a 3-source instance covers
// the out-of-range index path. Directed literal checks pin the model.
module tb_bus_read_sequencer;

  localparam int W      = 4;
  localparam int SETTLE = 2;
  localparam int NSRC_A = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  bus_read_sequencer_if #(.WIDTH(W), .NSRC(NSRC_A)) bif_a ();
  bus_read_sequencer_if #(.WIDTH(W), .NSRC(3))      bif_b ();

  bus_read_sequencer #(.WIDTH(W), .NSRC(NSRC_A), .SETTLE(SETTLE)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bif_a.master)
  );

  bus_read_sequencer #(.WIDTH(W), .NSRC(3), .SETTLE(SETTLE)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bif_b.master)
  );

  always #5 clk = ~clk;

  // Drivers on bus A: sources 0..2 are attached, source 3 floats
  function automatic logic [W-1:0] drv_val(input int s);
    case (s)
      0:       return 4'b0001;
      1:       return 4'b0000;
      2:       return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit drv_on(input int s);
    return (s >= 0) && (s <= 2);
  endfunction

  // Bus A: the enabled driver's word, unknown when nothing valid drives it
  always_comb begin
    case (bif_a.oe)
      4'b0001: bif_a.bus_in = 4'b0001;
      4'b0010: bif_a.bus_in = 4'b0000;
      4'b0100: bif_a.bus_in = 4'b0110;
      default: bif_a.bus_in = 4'bxxxx;
    endcase
  end

  assign bif_b.bus_in = 4'b1111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- transaction-level model of sequencer A ----------------
  int          m_left  = 0;    // enable cycles still to run for the read in flight
  int          m_sel   = 0;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_known = 1'b0; // captured word is meaningful
  logic [W-1:0]      m_data = '0;
  logic [NSRC_A-1:0] m_oe   = '0;
  bit          fourstate = 1'b0;
  bit          chk_on    = 1'b0;

  // Model advance on each edge: response pending, enable running, or idle
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      m_oe = '0; m_data = '0; m_known = 1'b0;
    end else if (m_valid) begin
      if (bif_a.rready) begin
        m_valid = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_oe    = '0;
        m_valid = 1'b1;
        m_data  = drv_val(m_sel);
        m_known = drv_on(m_sel);
        m_err   = !drv_on(m_sel) && fourstate;
      end
    end else if (bif_a.req) begin
      m_busy = 1'b1;
      m_sel  = int'(bif_a.src_sel);
      if (m_sel >= NSRC_A) begin
        m_valid = 1'b1; m_err = 1'b1; m_data = '0; m_known = 1'b1;
      end else begin
        m_left = SETTLE;
        m_oe   = NSRC_A'(1) << m_sel;
      end
    end
  end

  // ---------------- per-cycle compare and bus-safety tracking ----------------
  int   zrun    = 0;
  int   min_gap = 1000;
  int   en_cnt  = 0;
  bit   seen_en = 1'b0;
  logic [NSRC_A-1:0] prev_oe = '0;

  // Compare A against the model away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("oe",     bif_a.oe,     m_oe);
      check("rvalid", bif_a.rvalid, m_valid);
      check("err",    bif_a.err,    m_err);
      check("busy",   bif_a.busy,   m_busy);
      if (m_valid && m_known) check("rdata", bif_a.rdata, m_data);
      check("oe_onehot0", $onehot0(bif_a.oe), 1);
      if (bif_a.oe == '0) begin
        zrun++;
      end else if (prev_oe == '0) begin
        if (seen_en) begin
          check("oe_gap_ge2", (zrun >= 2), 1);
          if (zrun < min_gap) min_gap = zrun;
        end
        seen_en = 1'b1;
        en_cnt++;
        zrun = 0;
      end
      prev_oe = bif_a.oe;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [W-1:0] xprobe = 4'bxxxx;
  int first_rv;
  int oe_cyc;
  int en_before;

  task automatic wait_rvalid(input int maxc);
    int n = 0;
    while (n < maxc && bif_a.rvalid !== 1'b1) begin
      tick();
      n++;
    end
    check("rvalid_arrives", bif_a.rvalid, 1);
  endtask

  task automatic start_read(input logic [1:0] sel);
    bif_a.req = 1'b1;
    bif_a.src_sel = sel;
    tick();
    bif_a.req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bif_a.req = 1'b0; bif_a.src_sel = 2'd0; bif_a.rready = 1'b1;
    bif_b.req = 1'b0; bif_b.src_sel = 2'd0; bif_b.rready = 1'b1;
    fourstate = ((^xprobe) === 1'bx);
    rst = 1'b1;
    tick(); tick();
    // Reset state
    check("rst_oe",     bif_a.oe,     4'b0000);
    check("rst_rvalid", bif_a.rvalid, 1'b0);
    check("rst_busy",   bif_a.busy,   1'b0);
    check("rst_err",    bif_a.err,    1'b0);
    check("rst_rdata",  bif_a.rdata,  4'b0000);
    check("rst_b_rvalid", bif_b.rvalid, 1'b0);
    check("rst_b_busy",   bif_b.busy,   1'b0);
    rst = 1'b0;
    chk_on = 1'b1;
    tick();

    // Basic read of source 1 (drives 0): oe held 2 cycles, rvalid on the
    // 3rd edge counting the accepting edge
    bif_a.req = 1'b1; bif_a.src_sel = 2'd1;
    first_rv = 0; oe_cyc = 0;
    for (int k = 1; k <= 20 && first_rv == 0; k++) begin
      tick();
      if (k == 1) bif_a.req = 1'b0;
      if (bif_a.oe == 4'b0010) oe_cyc++;
      if (bif_a.rvalid === 1'b1) first_rv = k;
    end
    check("basic_rvalid_edge", first_rv, 3);
    check("basic_oe_cycles",   oe_cyc,   2);
    check("basic_rdata",       bif_a.rdata, 4'b0000);
    check("basic_err",         bif_a.err,   1'b0);
    tick();
    check("basic_rvalid_clr",  bif_a.rvalid, 1'b0);
    check("basic_busy_clr",    bif_a.busy,   1'b0);

    // Backpressure on a read of source 2
    bif_a.rready = 1'b0;
    start_read(2'd2);
    wait_rvalid(10);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_rvalid", bif_a.rvalid, 1'b1);
      check("bp_rdata",  bif_a.rdata,  4'b0110);
      check("bp_err",    bif_a.err,    1'b0);
      check("bp_oe",     bif_a.oe,     4'b0000);
    end
    bif_a.rready = 1'b1;
    tick();
    check("bp_release", bif_a.rvalid, 1'b0);

    // Floating bus on source 3, then a driven read of source 0
    start_read(2'd3);
    wait_rvalid(10);
    check("float_err", bif_a.err, fourstate);
    tick();
    start_read(2'd0);
    wait_rvalid(10);
    check("driven_rdata", bif_a.rdata, 4'b0001);
    check("driven_err",   bif_a.err,   1'b0);
    tick();

    // Back-to-back: req held high, sel toggling; one read per 4 edges
    en_before = en_cnt;
    bif_a.req = 1'b1; bif_a.src_sel = 2'd0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      bif_a.src_sel = bif_a.src_sel ^ 2'd1;
    end
    bif_a.req = 1'b0;
    check("b2b_enables", en_cnt - en_before, 10);
    check("b2b_min_gap", min_gap, 2);
    for (int k = 0; k < 12 && bif_a.busy === 1'b1; k++) tick();
    check("b2b_drained", bif_a.busy, 1'b0);
    tick();

    // Reset while the enable is active aborts the read
    start_read(2'd0);
    check("abort_oe_on", bif_a.oe, 4'b0001);
    rst = 1'b1;
    tick();
    check("abort_oe",     bif_a.oe,     4'b0000);
    check("abort_rvalid", bif_a.rvalid, 1'b0);
    check("abort_busy",   bif_a.busy,   1'b0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_rvalid", bif_a.rvalid, 1'b0);
    end

    // Out-of-range index on the 3-source instance
    bif_b.req = 1'b1; bif_b.src_sel = 2'd3;
    tick();
    bif_b.req = 1'b0;
    check("bad_oe",     bif_b.oe,     3'b000);
    check("bad_rvalid", bif_b.rvalid, 1'b1);
    check("bad_err",    bif_b.err,    1'b1);
    check("bad_rdata",  bif_b.rdata,  4'b0000);
    check("bad_busy",   bif_b.busy,   1'b1);
    tick();
    check("bad_done",   bif_b.rvalid, 1'b0);
    check("bad_idle",   bif_b.busy,   1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
